me_search_ctrl: RTL and testbench

Full-search motion-estimation controller for the inter-prediction path. It steps the PE array and SAD adder tree through every candidate motion vector in a square search window. It collects the resulting 16x16 SAD values, keeps the minimum and its motion vector, and reports them to the mode-decision stage. It owns sequencing only; SAD arithmetic stays in the datapath it drives.

---
 rtl/me_search_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_me_search_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/me_search_ctrl.sv
// ---------------------------------------------------------------------------
// me_search_ctrl
//
// Full-search motion-estimation sequencer. It walks every candidate motion
// vector of a square window (-RANGE..RANGE-1 on each axis, raster order:
// mvx fastest) out to the PE array / SAD tree. It collects the 16x16 SAD
// returned for each candidate and keeps the minimum together with its MV.
// No SAD arithmetic lives here.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle search request (honoured in IDLE only)
//   abort                 drop the search in progress, back to IDLE
//   busy                  high while issuing or draining
//   cand_valid/ready      candidate handshake toward the datapath
//   cand_mvx/cand_mvy     candidate displacement, two's complement
//   sad_valid/sad_in      SAD results, returned in issue order
//   done                  one-cycle pulse, best_* valid
//   best_sad/mvx/mvy      minimum SAD of the last completed search and its MV
//   dbg_state             current FSM state (IDLE=0 ISSUE=1 DRAIN=2 DONE=3)
//
// Handshake: a candidate moves on a rising edge where cand_valid and
// cand_ready are both high. cand_valid does not depend on cand_ready, and
// cand_mv* stay unchanged while cand_valid is high without cand_ready. Each
// cycle with sad_valid high returns exactly one result for the oldest
// outstanding candidate. There is no backpressure on the return path.
// ---------------------------------------------------------------------------
module me_search_ctrl #(
    parameter int SAD_WIDTH = 16,
    parameter int MV_WIDTH  = 6,
    parameter int RANGE     = 16,
    parameter int MAX_OUT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 cand_valid,
    input  logic                 cand_ready,
    output logic [MV_WIDTH-1:0]  cand_mvx,
    output logic [MV_WIDTH-1:0]  cand_mvy,
    input  logic                 sad_valid,
    input  logic [SAD_WIDTH-1:0] sad_in,
    output logic                 done,
    output logic [SAD_WIDTH-1:0] best_sad,
    output logic [MV_WIDTH-1:0]  best_mvx,
    output logic [MV_WIDTH-1:0]  best_mvy,
    output logic [1:0]           dbg_state
);

    localparam int TOTAL = (2 * RANGE) * (2 * RANGE);
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    localparam logic [MV_WIDTH-1:0] MV_MIN   = MV_WIDTH'(-RANGE);
    localparam logic [MV_WIDTH-1:0] MV_MAX   = MV_WIDTH'(RANGE - 1);
    localparam logic [MV_WIDTH-1:0] MV_ONE   = MV_WIDTH'(1);
    localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [OUT_W-1:0]    OUT_MAX  = OUT_W'(MAX_OUT);
    localparam logic [OUT_W-1:0]    OUT_ONE  = OUT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [MV_WIDTH-1:0]  iss_x_q, iss_x_d, iss_y_q, iss_y_d;
    logic [MV_WIDTH-1:0]  ret_x_q, ret_x_d, ret_y_q, ret_y_d;
    logic [CNT_W-1:0]     iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]     ret_cnt_q, ret_cnt_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic                 first_q, first_d;
    logic [SAD_WIDTH-1:0] best_sad_q, best_sad_d;
    logic [MV_WIDTH-1:0]  best_x_q, best_x_d, best_y_q, best_y_d;

    logic                 active;
    logic                 xfer;
    logic                 sad_acc;
    logic [MV_WIDTH-1:0]  iss_x_nxt, iss_y_nxt, ret_x_nxt, ret_y_nxt;

    assign active     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign cand_valid = (state_q == ST_ISSUE) && (out_q < OUT_MAX);
    assign xfer       = cand_valid && cand_ready;
    // A result with nothing outstanding, or in the abort cycle, is stray and
    // must not touch any state.
    assign sad_acc    = sad_valid && active && (out_q != '0) && !abort;

    // Raster advance: mvx runs up to RANGE-1, then wraps and mvy steps.
    // Past the final candidate mvy overflows, which is never used.
    assign iss_x_nxt = (iss_x_q == MV_MAX) ? MV_MIN : iss_x_q + MV_ONE;
    assign iss_y_nxt = (iss_x_q == MV_MAX) ? iss_y_q + MV_ONE : iss_y_q;
    assign ret_x_nxt = (ret_x_q == MV_MAX) ? MV_MIN : ret_x_q + MV_ONE;
    assign ret_y_nxt = (ret_x_q == MV_MAX) ? ret_y_q + MV_ONE : ret_y_q;

    always_comb begin
        state_d    = state_q;
        iss_x_d    = iss_x_q;
        iss_y_d    = iss_y_q;
        ret_x_d    = ret_x_q;
        ret_y_d    = ret_y_q;
        iss_cnt_d  = iss_cnt_q;
        ret_cnt_d  = ret_cnt_q;
        out_d      = out_q;
        first_d    = first_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;

        case (state_q)
            ST_IDLE: begin
                // abort outranks a simultaneous start
                if (start && !abort) begin
                    state_d   = ST_ISSUE;
                    iss_x_d   = MV_MIN;
                    iss_y_d   = MV_MIN;
                    ret_x_d   = MV_MIN;
                    ret_y_d   = MV_MIN;
                    iss_cnt_d = '0;
                    ret_cnt_d = '0;
                    out_d     = '0;
                    first_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (xfer && (iss_cnt_q == LAST_IDX)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sad_acc && (ret_cnt_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (active) begin
            if (xfer) begin
                iss_x_d   = iss_x_nxt;
                iss_y_d   = iss_y_nxt;
                iss_cnt_d = iss_cnt_q + CNT_ONE;
            end

            if (xfer && !sad_acc) begin
                out_d = out_q + OUT_ONE;
            end else if (!xfer && sad_acc) begin
                out_d = out_q - OUT_ONE;
            end

            if (sad_acc) begin
                ret_x_d   = ret_x_nxt;
                ret_y_d   = ret_y_nxt;
                ret_cnt_d = ret_cnt_q + CNT_ONE;
                first_d   = 1'b0;
                // strict compare: equal SADs keep the earlier raster candidate
                if (first_q || (sad_in < best_sad_q)) begin
                    best_sad_d = sad_in;
                    best_x_d   = ret_x_q;
                    best_y_d   = ret_y_q;
                end
            end
        end

        // Candidates still in the datapath are forgotten; their late
        // results fall on outstanding == 0 and are dropped.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            out_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            iss_x_q    <= '0;
            iss_y_q    <= '0;
            ret_x_q    <= '0;
            ret_y_q    <= '0;
            iss_cnt_q  <= '0;
            ret_cnt_q  <= '0;
            out_q      <= '0;
            first_q    <= 1'b0;
            best_sad_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            iss_x_q    <= iss_x_d;
            iss_y_q    <= iss_y_d;
            ret_x_q    <= ret_x_d;
            ret_y_q    <= ret_y_d;
            iss_cnt_q  <= iss_cnt_d;
            ret_cnt_q  <= ret_cnt_d;
            out_q      <= out_d;
            first_q    <= first_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
        end
    end

    assign busy      = active;
    assign done      = (state_q == ST_DONE);
    assign cand_mvx  = iss_x_q;
    assign cand_mvy  = iss_y_q;
    assign best_sad  = best_sad_q;
    assign best_mvx  = best_x_q;
    assign best_mvy  = best_y_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_me_search_ctrl
//
// Drives me_search_ctrl with RANGE=2 (16 candidates) and MAX_OUT=4. A table
// of searches gives the SAD pattern, datapath latency, ready behaviour,
// optional abort/reset event and the expected best result. A scoreboard
// queue holds the raster-ordered MVs and each accepted candidate pops one.
// A latency queue models the datapath returning SADs in order.
// ---------------------------------------------------------------------------
module tb_me_search_ctrl;

    localparam int SW  = 16;
    localparam int MW  = 6;
    localparam int RG  = 2;
    localparam int MO  = 4;
    localparam int TOT = (2 * RG) * (2 * RG);
    localparam int NV  = 9;

    typedef struct {
        int pat;
        int lat;
        bit rnd;
        int abort_at;
        bit rst_drain;
        int exp_sad;
        int exp_x;
        int exp_y;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cand_ready = 1'b0;
    logic          sad_valid = 1'b0;
    logic [SW-1:0] sad_in = '0;
    logic          busy, cand_valid, done;
    logic [MW-1:0] cand_mvx, cand_mvy, best_mvx, best_mvy;
    logic [SW-1:0] best_sad;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [2*MW-1:0] exp_q[$];
    int              due_q[$];
    logic [SW-1:0]   psad_q[$];
    vec_t            tbl[NV];

    me_search_ctrl #(
        .SAD_WIDTH(SW), .MV_WIDTH(MW), .RANGE(RG), .MAX_OUT(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_mvx(cand_mvx), .cand_mvy(cand_mvy),
        .sad_valid(sad_valid), .sad_in(sad_in), .done(done),
        .best_sad(best_sad), .best_mvx(best_mvx), .best_mvy(best_mvy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] mv6(input int v);
        return MW'(v);
    endfunction

    function automatic logic [SW-1:0] sad_of(input int pat, input int idx);
        case (pat)
            0:       return (idx == 9) ? SW'(5) : SW'(100 + 7 * idx);
            1:       return SW'(40);
            2:       return SW'(500 - 20 * idx);
            default: return ((idx % 5) == 3) ? SW'(7) : SW'(60);
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_cand_valid"}, 32'(cand_valid), 32'd0);
        chk({tag, "_cand_mvx"},  32'(cand_mvx), 32'd0);
        chk({tag, "_cand_mvy"},  32'(cand_mvy), 32'd0);
        chk({tag, "_done"},      32'(done), 32'd0);
        chk({tag, "_best_sad"},  32'(best_sad), 32'd0);
        chk({tag, "_best_mvx"},  32'(best_mvx), 32'd0);
        chk({tag, "_best_mvy"},  32'(best_mvy), 32'd0);
        chk({tag, "_state"},     32'(dbg_state), 32'd0);
    endtask

    task automatic run_entry(input vec_t e);
        int              issued, rets, inflight, cyc;
        bit              fin, stop, stall_pend;
        logic [2*MW-1:0] held, exp_mv;
        logic [MW-1:0]   ex, ey;

        exp_q.delete();
        due_q.delete();
        psad_q.delete();
        for (int y = -RG; y < RG; y++)
            for (int x = -RG; x < RG; x++)
                exp_q.push_back({mv6(y), mv6(x)});

        @(negedge clk);
        start = 1'b1; abort = 1'b0; sad_valid = 1'b0; cand_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;

        issued = 0; rets = 0; inflight = 0; cyc = 0;
        fin = 1'b0; stop = 1'b0; stall_pend = 1'b0; held = '0;
        while (!fin && !stop && cyc < 600) begin
            if (rets == TOT) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_at_done", 32'(busy), 32'd0);
                fin = 1'b1;
            end else begin
                chk("done_early", 32'(done), 32'd0);
                chk("busy", 32'(busy), 32'd1);
                chk("cand_valid", 32'(cand_valid), 32'(issued < TOT && inflight < MO));
                if (stall_pend) chk("stall_hold", 32'({cand_mvy, cand_mvx}), 32'(held));
            end
            if (!fin) begin
                if (e.abort_at != 0 && issued == e.abort_at) begin
                    abort = 1'b1; cand_ready = 1'b0; sad_valid = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_cand_valid", 32'(cand_valid), 32'd0);
                    chk("abort_done", 32'(done), 32'd0);
                    chk("abort_state", 32'(dbg_state), 32'd0);
                    for (int k = 0; k < 4; k++) begin
                        sad_valid = 1'b1; sad_in = '0;
                        @(negedge clk);
                        chk("late_sad_done", 32'(done), 32'd0);
                        chk("late_sad_busy", 32'(busy), 32'd0);
                    end
                    sad_valid = 1'b0;
                    stop = 1'b1;
                end else if (e.rst_drain && issued == TOT && rets < TOT) begin
                    chk("in_drain", 32'(dbg_state), 32'd2);
                    rst_n = 1'b0; cand_ready = 1'b0; sad_valid = 1'b0;
                    #1;
                    check_reset_outputs("drain_rst");
                    @(negedge clk);
                    rst_n = 1'b1;
                    stop = 1'b1;
                end else begin
                    cand_ready = e.rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
                    sad_valid = 1'b0;
                    if (due_q.size() > 0 && due_q[0] <= cyc) begin
                        void'(due_q.pop_front());
                        sad_in = psad_q.pop_front();
                        sad_valid = 1'b1;
                        rets++;
                        inflight--;
                    end
                    stall_pend = cand_valid && !cand_ready;
                    held = {cand_mvy, cand_mvx};
                    if (cand_valid && cand_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("extra_cand", 32'd1, 32'd0);
                        end else begin
                            exp_mv = exp_q.pop_front();
                            chk("cand_mv", 32'({cand_mvy, cand_mvx}), 32'(exp_mv));
                        end
                        due_q.push_back(cyc + e.lat);
                        psad_q.push_back(sad_of(e.pat, issued));
                        issued++;
                        inflight++;
                    end
                    cyc++;
                    @(negedge clk);
                end
            end
        end
        sad_valid = 1'b0;
        cand_ready = 1'b0;
        if (!fin && !stop) chk("timeout", 32'd0, 32'd1);
        if (fin) begin
            chk("all_cands_issued", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        ex = mv6(e.exp_x);
        ey = mv6(e.exp_y);
        chk("best_sad", 32'(best_sad), 32'(e.exp_sad));
        chk("best_mvx", 32'(best_mvx), 32'(ex));
        chk("best_mvy", 32'(best_mvy), 32'(ey));
    endtask

    initial begin
        //          pat lat rnd abort rst  sad  x   y
        tbl[0] = '{0, 1, 1'b0, 0, 1'b0,   5, -1,  0};
        tbl[1] = '{1, 1, 1'b0, 0, 1'b0,  40, -2, -2};
        tbl[2] = '{0, 8, 1'b0, 0, 1'b0,   5, -1,  0};
        tbl[3] = '{2, 3, 1'b1, 0, 1'b0, 200,  1,  1};
        tbl[4] = '{3, 2, 1'b1, 0, 1'b0,   7,  1, -2};
        tbl[5] = '{0, 1, 1'b0, 6, 1'b0, 100, -2, -2};
        tbl[6] = '{3, 1, 1'b0, 0, 1'b0,   7,  1, -2};
        tbl[7] = '{0, 8, 1'b0, 0, 1'b1,   0,  0,  0};
        tbl[8] = '{2, 1, 1'b1, 0, 1'b0, 200,  1,  1};

        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // abort and start together in IDLE: the start must be ignored
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_cand_valid", 32'(cand_valid), 32'd0);
        chk("abort_start_state", 32'(dbg_state), 32'd0);

        for (int i = 0; i < NV; i++) run_entry(tbl[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
